// File: rtl/quick_spi_cmd_queue.sv
// Command queue and launch sequencer in front of the quick_spi master. It buffers host
// writes, launches them one at a time, and watches ss_n to tell when each one is done.
// Define QUICK_SPI_CMDQ_FLUSH_EN to add the synchronous flush input.
module quick_spi_cmd_queue #(
  parameter int DATA_WIDTH       = 16,
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int GAP_CYCLES       = 2,
  parameter int START_TIMEOUT    = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [NUMBER_OF_SLAVES-1:0]     cmd_slave,
  input  logic [DATA_WIDTH-1:0]           cmd_data,
  output logic                            start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]     slave,
  output logic [DATA_WIDTH-1:0]           outgoing_data,
  input  logic [NUMBER_OF_SLAVES-1:0]     spi_ss_n,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     tx_count,
  output logic                            timeout_err,
  input  logic                            err_clear,
`ifdef QUICK_SPI_CMDQ_FLUSH_EN
  input  logic                            flush,
`endif
  output logic [1:0]                      dbg_state
);

  // Host side: cmd_valid/cmd_ready transfer one command on every clk edge where both
  // are high; cmd_ready depends only on the registered level, never on cmd_valid.

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_SELECT  = 2'd1,
    S_WAIT_RELEASE = 2'd2,
    S_GAP          = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]              level_q, level_d;
  logic [NUMBER_OF_SLAVES-1:0]   slave_q, slave_d;
  logic [DATA_WIDTH-1:0]         data_q, data_d;
  logic                          start_q, start_d;
  logic [15:0]                   tx_q, tx_d;
  logic                          err_q, err_d;

  logic [NUMBER_OF_SLAVES-1:0]   mem_slave_q [FIFO_DEPTH];
  logic [NUMBER_OF_SLAVES-1:0]   mem_slave_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]         mem_data_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]         mem_data_d  [FIFO_DEPTH];

  logic push;
  logic launch;
  logic ss_idle;
  logic err_set;
  logic flush_now;

`ifdef QUICK_SPI_CMDQ_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign cmd_ready = (level_q != LVL_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign launch    = (state_q == S_IDLE) && (level_q != '0);
  assign ss_idle   = &spi_ss_n;

  // Sequencer: a launch is only ever decided in IDLE, so the master cannot be
  // re-triggered while a transfer or the post-transfer gap is still running.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    start_d = 1'b0;
    slave_d = slave_q;
    data_d  = data_q;
    tx_d    = tx_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          start_d = 1'b1;
          slave_d = mem_slave_q[rd_ptr_q];
          data_d  = mem_data_q[rd_ptr_q];
          timer_d = '0;
          state_d = S_WAIT_SELECT;
        end
      end
      S_WAIT_SELECT: begin
        if (!ss_idle) begin
          state_d = S_WAIT_RELEASE;
        end else if (timer_q == START_LAST) begin
          err_set = 1'b1;
          timer_d = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (ss_idle) begin
          tx_d    = tx_q + 16'd1;
          timer_d = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage and pointers; a flush realigns the write pointer to the post-pop read pointer.
  always_comb begin
    mem_slave_d = mem_slave_q;
    mem_data_d  = mem_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (push && !flush_now) begin
      mem_slave_d[wr_ptr_q] = cmd_slave;
      mem_data_d[wr_ptr_q]  = cmd_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (launch) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !launch) begin
      level_d = level_q + LVL_W'(1);
    end else if (launch && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    if (flush_now) begin
      wr_ptr_d = rd_ptr_d;
      level_d  = '0;
    end
  end

  // A set in the same cycle as err_clear must survive, so it is applied last.
  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      slave_q  <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      tx_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      slave_q  <= slave_d;
      data_q   <= data_d;
      start_q  <= start_d;
      tx_q     <= tx_d;
      err_q    <= err_d;
    end
  end

  // Entry contents need no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_slave_q <= mem_slave_d;
    mem_data_q  <= mem_data_d;
  end

  assign start_transaction = start_q;
  assign slave             = slave_q;
  assign outgoing_data     = data_q;
  assign busy              = (state_q != S_IDLE);
  assign fifo_level        = level_q;
  assign tx_count          = tx_q;
  assign timeout_err       = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_quick_spi_cmd_queue.sv
// Randomized bench for quick_spi_cmd_queue: a behavioural SPI master answers each
// launch through ss_n, and a command scoreboard checks launch order and contents.
module tb_quick_spi_cmd_queue;
  localparam int DW    = 16;
  localparam int NS    = 2;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int STO   = 8;
  localparam int CW    = NS + DW;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            err_clear = 1'b0;
  logic [NS-1:0]   cmd_slave = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [NS-1:0]   spi_ss_n = '1;
  logic            cmd_ready;
  logic            start_transaction;
  logic [NS-1:0]   slave;
  logic [DW-1:0]   outgoing_data;
  logic            busy;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0]     tx_count;
  logic            timeout_err;
  logic [1:0]      dbg_state;
`ifdef QUICK_SPI_CMDQ_FLUSH_EN
  logic            flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_q[$];
  int  edge_cnt = 0;
  int  exp_tx = 0;
  int  tx_base = 0;
  int  rst_epoch = 0;
  int  n_pulse = 0;
  int  last_pulse_edge = 0;
  int  rel_edge = 0;
  int  n_release = 0;
  bit  ss_respond = 1'b1;
  bit  master_active = 1'b0;
  int  sel_delay = 3;
  int  hold_cycles = 10;

  quick_spi_cmd_queue #(
    .DATA_WIDTH(DW), .NUMBER_OF_SLAVES(NS), .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP), .START_TIMEOUT(STO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slave(cmd_slave), .cmd_data(cmd_data), .start_transaction(start_transaction),
    .slave(slave), .outgoing_data(outgoing_data), .spi_ss_n(spi_ss_n), .busy(busy),
    .fifo_level(fifo_level), .tx_count(tx_count), .timeout_err(timeout_err),
    .err_clear(err_clear),
`ifdef QUICK_SPI_CMDQ_FLUSH_EN
    .flush(flush),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // Behavioural master: logs every launch, then selects and releases the slave
  always begin
    int       ep;
    logic [NS-1:0] s;
    @(posedge clk); #2;
    if (reset_n && start_transaction) begin
      n_pulse++;
      last_pulse_edge = edge_cnt;
      got_q.push_back({slave, outgoing_data});
      if (ss_respond) begin
        ep = rst_epoch;
        s = slave;
        master_active = 1'b1;
        repeat (sel_delay) @(posedge clk);
        #2 spi_ss_n = ~(NS'(1) << s);
        repeat (hold_cycles) @(posedge clk);
        #2 spi_ss_n = '1;
        rel_edge = edge_cnt;
        n_release++;
        if (ep == rst_epoch) exp_tx++;
        master_active = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic push_cmd(input logic [NS-1:0] s, input logic [DW-1:0] d);
    cmd_slave = s;
    cmd_data = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !cmd_ready; i++) tick();
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_wait cmd_ready got 0 want 1 within 400 cycles");
      cmd_valid = 1'b0;
    end else begin
      tick();
      exp_q.push_back({s, d});
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (!busy && !master_active && fifo_level == 0) break;
      tick();
    end
    if (i == 3000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle busy=%0b level=%0d still pending after 3000 cycles", busy, fifo_level);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_checks++; if (start_transaction !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start_transaction); end
    n_checks++; if (slave !== '0) begin n_fail++; $display("FAIL reset_slave got %h want 0", slave); end
    n_checks++; if (outgoing_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", outgoing_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL reset_tx got %0d want 0", tx_count); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", timeout_err); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int nr;
    logic [CW-1:0] g, e;
    ss_respond = 1'b1; sel_delay = 3; hold_cycles = 40;
    push_cmd(2'd1, 16'hA5C3);
    n_checks++; if (fifo_level !== LVL_W'(1)) begin n_fail++; $display("FAIL single_level_pre got %0d want 1", fifo_level); end
    n_checks++; if (start_transaction !== 1'b0) begin n_fail++; $display("FAIL single_start_early got %b want 0", start_transaction); end
    tick();
    n_checks++; if (start_transaction !== 1'b1) begin n_fail++; $display("FAIL single_start got %b want 1", start_transaction); end
    n_checks++; if (slave !== 2'd1) begin n_fail++; $display("FAIL single_slave got %0d want 1", slave); end
    n_checks++; if (outgoing_data !== 16'hA5C3) begin n_fail++; $display("FAIL single_data got %h want a5c3", outgoing_data); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL single_level_post got %0d want 0", fifo_level); end
    tick();
    n_checks++; if (start_transaction !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %b want 0", start_transaction); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    push_cmd(2'd0, DW'($urandom));
    nr = n_release;
    for (int i = 0; i < 300 && n_release == nr; i++) tick();
    n_checks++; if (n_release == nr) begin n_fail++; $display("FAIL single_release_wait got none want release"); end
    tick();
    n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_tx got %0d want 1", tx_count); end
    for (int k = 0; k < GAP; k++) begin
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy cycle %0d got %b want 1", k, busy); end
      tick();
    end
    n_checks++; if (busy !== 1'b0 || start_transaction !== 1'b0) begin n_fail++; $display("FAIL gap_end busy=%b start=%b want 0 0", busy, start_transaction); end
    tick();
    n_checks++; if (start_transaction !== 1'b1 || last_pulse_edge != rel_edge + GAP + 2) begin
      n_fail++; $display("FAIL gap_relaunch start=%b edge got %0d want %0d", start_transaction, last_pulse_edge, rel_edge + GAP + 2);
    end
    wait_idle();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL single_sb got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (tx_count !== 16'(exp_tx - tx_base)) begin n_fail++; $display("FAIL single_tx_end got %0d want %0d", tx_count, exp_tx - tx_base); end
  endtask

  task automatic test_back_to_back();
    int i;
    logic [CW-1:0] g, e;
    ss_respond = 1'b1; sel_delay = 2; hold_cycles = 60;
    push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    tick(); tick();
    for (int k = 0; k < DEPTH; k++) push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    n_checks++; if (fifo_level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL full_level got %0d want %0d", fifo_level, DEPTH); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", cmd_ready); end
    cmd_slave = NS'($urandom_range(0, NS-1)); cmd_data = DW'($urandom); cmd_valid = 1'b1;
    for (i = 0; i < 400 && !cmd_ready; i++) tick();
    n_checks++; if (fifo_level !== LVL_W'(DEPTH - 1)) begin n_fail++; $display("FAIL full_reopen_level got %0d want %0d", fifo_level, DEPTH - 1); end
    tick();
    exp_q.push_back({cmd_slave, cmd_data});
    cmd_valid = 1'b0;
    hold_cycles = 5;
    n_checks++; if (fifo_level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL full_fifth_level got %0d want %0d", fifo_level, DEPTH); end
    wait_idle();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL full_sb got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (tx_count !== 16'(exp_tx - tx_base)) begin n_fail++; $display("FAIL full_tx got %0d want %0d", tx_count, exp_tx - tx_base); end
  endtask

  task automatic test_timeout();
    int cnt;
    int tx_before;
    logic [CW-1:0] g, e;
    ss_respond = 1'b0; sel_delay = 2; hold_cycles = 4;
    tx_before = exp_tx - tx_base;
    push_cmd(2'd0, DW'($urandom));
    push_cmd(2'd1, DW'($urandom));
    for (int i = 0; i < 20 && !start_transaction; i++) tick();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", timeout_err); end
    cnt = 0;
    while (cnt < 50 && !timeout_err) begin tick(); cnt++; end
    ss_respond = 1'b1;
    n_checks++; if (cnt != STO) begin n_fail++; $display("FAIL timeout_cycles got %0d want %0d", cnt, STO); end
    n_checks++; if (tx_count !== 16'(tx_before)) begin n_fail++; $display("FAIL timeout_tx got %0d want %0d", tx_count, tx_before); end
    cnt = 0;
    while (cnt < 50 && !start_transaction) begin tick(); cnt++; end
    n_checks++; if (cnt != GAP + 1) begin n_fail++; $display("FAIL timeout_relaunch got %0d cycles want %0d", cnt, GAP + 1); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", timeout_err); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", timeout_err); end
    wait_idle();
    ss_respond = 1'b0;
    err_clear = 1'b1;
    push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    for (int i = 0; i < 20 && !start_transaction; i++) tick();
    for (int k = 1; k <= STO; k++) begin
      tick();
      if (k == STO - 1) begin
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL set_wins_pre got %b want 0", timeout_err); end
      end
    end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b want 1", timeout_err); end
    tick();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL set_wins_clear got %b want 0", timeout_err); end
    err_clear = 1'b0;
    ss_respond = 1'b1;
    wait_idle();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL timeout_sb got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (tx_count !== 16'(tx_before + 1)) begin n_fail++; $display("FAIL timeout_tx_end got %0d want %0d", tx_count, tx_before + 1); end
  endtask

  task automatic test_reset_mid();
    int np;
    ss_respond = 1'b1; sel_delay = 2; hold_cycles = 50;
    push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    for (int i = 0; i < 30 && spi_ss_n == '1; i++) tick();
    tick();
    for (int k = 0; k < 3; k++) push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    n_checks++; if (fifo_level !== LVL_W'(3) || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre level=%0d busy=%b want 3 1", fifo_level, busy); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_tx got %0d want 0", tx_count); end
    n_checks++; if (start_transaction !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_start start=%b ready=%b want 0 1", start_transaction, cmd_ready); end
    reset_n = 1'b1;
    rst_epoch++;
    exp_q.delete(); got_q.delete();
    tx_base = exp_tx;
    np = n_pulse;
    repeat (10) tick();
    wait_idle();
    n_checks++; if (n_pulse != np) begin n_fail++; $display("FAIL rstmid_nolaunch got %0d pulses want 0", n_pulse - np); end
    n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_tx_end got %0d want 0", tx_count); end
  endtask

`ifdef QUICK_SPI_CMDQ_FLUSH_EN
  task automatic test_flush();
    int np;
    int tx_before;
    logic [CW-1:0] g, e;
    ss_respond = 1'b1; sel_delay = 2; hold_cycles = 40;
    tx_before = exp_tx - tx_base;
    push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    for (int i = 0; i < 30 && spi_ss_n == '1; i++) tick();
    tick();
    for (int k = 0; k < 3; k++) push_cmd(NS'($urandom_range(0, NS-1)), DW'($urandom));
    cmd_slave = 2'd1; cmd_data = DW'($urandom); cmd_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL flush_level got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy got %b want 1", busy); end
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    np = n_pulse;
    wait_idle();
    repeat (GAP + 4) tick();
    n_checks++; if (n_pulse != np) begin n_fail++; $display("FAIL flush_nolaunch got %0d pulses want 0", n_pulse - np); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL flush_sb got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (tx_count !== 16'(tx_before + 1)) begin n_fail++; $display("FAIL flush_tx got %0d want %0d", tx_count, tx_before + 1); end
  endtask
`endif

  task automatic test_random();
    int  pushes;
    logic rdy;
    logic [CW-1:0] g, e;
    pushes = 0;
    ss_respond = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) begin
        sel_delay = $urandom_range(1, 6);
        hold_cycles = $urandom_range(1, 12);
      end
      if (!cmd_valid && pushes < 40 && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_slave = NS'($urandom_range(0, NS-1));
        cmd_data = DW'($urandom);
      end
      rdy = cmd_ready;
      tick();
      if (cmd_valid && rdy) begin
        exp_q.push_back({cmd_slave, cmd_data});
        pushes++;
        cmd_valid = 1'b0;
      end
      n_checks++;
      if (fifo_level !== LVL_W'(exp_q.size() - got_q.size())) begin
        n_fail++; $display("FAIL rand_level cycle %0d got %0d want %0d", c, fifo_level, exp_q.size() - got_q.size());
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL rand_sb got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++; if (tx_count !== 16'(exp_tx - tx_base)) begin n_fail++; $display("FAIL rand_tx got %0d want %0d", tx_count, exp_tx - tx_base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_random();
`ifdef QUICK_SPI_CMDQ_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
